// File: rtl/data_mem_bytelane.sv
// MEM-stage data memory for the 32-bit MIPS core: byte/half/word stores and loads,
// with fault reporting. Optional macro DATA_MEM_WRITE_FORWARD_EN gives write-first same-word loads.
module data_mem_bytelane #(
    parameter int DEPTH     = 256,
    parameter int ADDR_W    = 32,
    parameter int INIT_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       write_data,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        size,
    input  logic              ld_unsigned,
    output logic [31:0]       read_data,
    output logic              rd_valid,
    output logic              fault,
    output logic [1:0]        fault_code
);

    localparam int DATA_W = 32;
    localparam int IDX_W  = $clog2(DEPTH);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_ALIGN = 2'b01;
    localparam logic [1:0] FC_RANGE = 2'b10;
    localparam logic [1:0] FC_SIZE  = 2'b11;

    localparam logic [DATA_W-1:0] INIT_VAL = (INIT_ZERO != 0) ? '0 : 'x;

    // Contents survive reset; only the output registers are cleared.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT_VAL};

    // Lane select plus sign/zero extension of the loaded word.
    function automatic logic [DATA_W-1:0] load_ext(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        lane,
        input logic [1:0]        sz,
        input logic              uns
    );
        logic        [7:0]        b;
        logic        [15:0]       h;
        logic signed [7:0]        bs;
        logic signed [15:0]       hs;
        logic signed [DATA_W-1:0] r;
        b  = word[{lane, 3'b000} +: 8];
        h  = lane[1] ? word[31:16] : word[15:0];
        bs = b;
        hs = h;
        case (sz)
            SZ_BYTE: r = uns ? {24'b0, b} : DATA_W'(bs);
            SZ_HALF: r = uns ? {16'b0, h} : DATA_W'(hs);
            default: r = word;
        endcase
        return r;
    endfunction

    // ---- p0: request decode, access check, lane enables ----
    logic [IDX_W-1:0]  word_idx_p0;
    logic [1:0]        lane_p0;
    logic              req_p0;
    logic [1:0]        code_p0;
    logic              ok_p0;
    logic              ld_ok_p0;
    logic              st_ok_p0;
    logic [3:0]        be_p0;
    logic [DATA_W-1:0] wdata_rep_p0;
    logic [DATA_W-1:0] rd_word_p0;
    logic [DATA_W-1:0] ld_word_p0;

    assign word_idx_p0 = addr[IDX_W+1:2];
    assign lane_p0     = addr[1:0];
    assign req_p0      = MemRead | MemWrite;

    always_comb begin
        code_p0 = FC_NONE;
        if (req_p0) begin
            if (size == FC_SIZE)
                code_p0 = FC_SIZE;
            else if ((size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr[1:0] != 2'b00))
                code_p0 = FC_ALIGN;
            else if ((addr >> (IDX_W + 2)) != '0)
                code_p0 = FC_RANGE;
        end
    end

    assign ok_p0    = req_p0 && (code_p0 == FC_NONE);
    assign ld_ok_p0 = ok_p0 && MemRead;
    assign st_ok_p0 = ok_p0 && MemWrite;

    always_comb begin
        be_p0        = 4'b0000;
        wdata_rep_p0 = write_data;
        case (size)
            SZ_BYTE: begin
                be_p0        = 4'b0001 << lane_p0;
                wdata_rep_p0 = {4{write_data[7:0]}};
            end
            SZ_HALF: begin
                be_p0        = lane_p0[1] ? 4'b1100 : 4'b0011;
                wdata_rep_p0 = {2{write_data[15:0]}};
            end
            SZ_WORD: be_p0 = 4'b1111;
            default: be_p0 = 4'b0000;
        endcase
    end

    assign rd_word_p0 = mem[word_idx_p0];

`ifdef DATA_MEM_WRITE_FORWARD_EN
    // A single address port means a simultaneous store always hits the loaded word.
    logic [DATA_W-1:0] merged_p0;
    always_comb begin
        merged_p0 = rd_word_p0;
        for (int i = 0; i < 4; i++) begin
            if (st_ok_p0 && be_p0[i])
                merged_p0[8*i +: 8] = wdata_rep_p0[8*i +: 8];
        end
    end
    assign ld_word_p0 = merged_p0;
`else
    assign ld_word_p0 = rd_word_p0;
`endif

    always_ff @(posedge clk) begin
        if (rst_n && st_ok_p0) begin
            for (int i = 0; i < 4; i++) begin
                if (be_p0[i])
                    mem[word_idx_p0][8*i +: 8] <= wdata_rep_p0[8*i +: 8];
            end
        end
    end

    // ---- p1: registered load result and fault pulse ----
    logic [DATA_W-1:0] read_data_p1;
    logic              vld_p1;
    logic              fault_p1;
    logic [1:0]        code_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data_p1 <= '0;
            vld_p1       <= 1'b0;
            fault_p1     <= 1'b0;
            code_p1      <= FC_NONE;
        end else begin
            vld_p1   <= ld_ok_p0;
            fault_p1 <= req_p0 && (code_p0 != FC_NONE);
            code_p1  <= code_p0;
            if (ld_ok_p0)
                read_data_p1 <= load_ext(ld_word_p0, lane_p0, size, ld_unsigned);
        end
    end

    assign read_data  = read_data_p1;
    assign rd_valid   = vld_p1;
    assign fault      = fault_p1;
    assign fault_code = code_p1;

endmodule

// File: tb/tb_data_mem_bytelane.sv
// Scoreboard bench for data_mem_bytelane: byte-array reference model, directed plan
// cases followed by randomized loads/stores.
module tb_data_mem_bytelane;

    localparam int DEPTH = 256;
    localparam int BYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] write_data = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        ld_unsigned = 1'b0;
    logic [31:0] read_data;
    logic        rd_valid;
    logic        fault;
    logic [1:0]  fault_code;

    data_mem_bytelane #(.DEPTH(DEPTH), .ADDR_W(32), .INIT_ZERO(1)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .write_data(write_data),
        .MemRead(MemRead), .MemWrite(MemWrite), .size(size), .ld_unsigned(ld_unsigned),
        .read_data(read_data), .rd_valid(rd_valid), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        vld;
        logic        flt;
        logic [1:0]  code;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mb [BYTES];
    logic [31:0] model_rd = '0;
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] a, input int nb, input bit uns);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < nb; i++) v |= 32'(mb[a + 32'(i)]) << (8 * i);
        if (!uns && nb < 4 && v[8*nb-1]) v |= 32'hFFFF_FFFF << (8 * nb);
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input int nb, input logic [31:0] wd);
        for (int i = 0; i < nb; i++) mb[a + 32'(i)] = 8'(wd >> (8 * i));
    endtask

    // Reference: the spec's rules applied to a flat byte array.
    task automatic model_step(input bit rd, input bit wr, input logic [31:0] a,
                              input logic [1:0] sz, input bit uns, input logic [31:0] wd);
        exp_t e;
        logic [1:0] code;
        int nb;
        if (!rst_n || !(rd || wr)) return;
        nb = 1 << sz;
        if (sz == 2'd3) code = 2'b11;
        else if ((sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)) code = 2'b01;
        else if (a >= 32'(BYTES)) code = 2'b10;
        else code = 2'b00;
        e.cyc = cyc;
        e.code = code;
        if (code != 2'b00) begin
            e.data = model_rd; e.vld = 1'b0; e.flt = 1'b1;
            sb.push_back(e);
            return;
        end
`ifdef DATA_MEM_WRITE_FORWARD_EN
        if (wr) model_store(a, nb, wd);
        if (rd) model_rd = model_load(a, nb, uns);
`else
        if (rd) model_rd = model_load(a, nb, uns);
        if (wr) model_store(a, nb, wd);
`endif
        if (rd) begin
            e.data = model_rd; e.vld = 1'b1; e.flt = 1'b0;
            sb.push_back(e);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge with strobes dropped.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [1:0] sz, input bit uns, input logic [31:0] wd);
        MemRead = rd; MemWrite = wr; addr = a; size = sz; ld_unsigned = uns; write_data = wd;
        model_step(rd, wr, a, sz, uns, wd);
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge clk) begin
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].cyc + 1 < cyc) begin
                total++; bad++;
                $display("FAIL missing_resp: got none expected response issued at cycle %0d", sb[0].cyc);
                void'(sb.pop_front());
            end
            if (rd_valid || fault) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_resp: got rd_valid=%0b fault=%0b expected idle", rd_valid, fault);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_cycle", 32'(cyc), 32'(e.cyc + 1));
                    chk("rd_valid", 32'(rd_valid), 32'(e.vld));
                    chk("fault", 32'(fault), 32'(e.flt));
                    chk("fault_code", 32'(fault_code), 32'(e.code));
                    chk("read_data", read_data, e.data);
                end
            end else if (fault_code != 2'b00) begin
                chk("fault_code_idle", 32'(fault_code), 32'd0);
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got no completion expected finish within 20000 cycles");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        bit          rd, wr;
        for (int i = 0; i < BYTES; i++) mb[i] = 8'h00;

        idle(2);
        chk("reset_read_data", read_data, 32'h0);
        chk("reset_rd_valid", 32'(rd_valid), 32'h0);
        chk("reset_fault", 32'(fault), 32'h0);
        chk("reset_fault_code", 32'(fault_code), 32'h0);
        rst_n = 1'b1;
        idle(1);

        access(0, 1, 32'h10, 2'd2, 0, 32'hDEADBEEF);
        access(1, 0, 32'h13, 2'd0, 0, 0);  chk("lb_13", read_data, 32'hFFFFFFDE);
        access(1, 0, 32'h10, 2'd0, 1, 0);  chk("lbu_10", read_data, 32'h000000EF);
        access(1, 0, 32'h12, 2'd1, 0, 0);  chk("lh_12", read_data, 32'hFFFFDEAD);
        access(1, 0, 32'h10, 2'd1, 1, 0);  chk("lhu_10", read_data, 32'h0000BEEF);
        access(0, 1, 32'h11, 2'd0, 0, 32'h55);
        access(1, 0, 32'h10, 2'd2, 0, 0);  chk("lw_after_sb", read_data, 32'hDEAD55EF);

        access(1, 0, 32'h02, 2'd2, 0, 0);
        chk("misalign_code", 32'(fault_code), 32'h1);
        chk("misalign_hold", read_data, 32'hDEAD55EF);
        access(0, 1, 32'h01, 2'd1, 0, 32'hFFFF);
        access(1, 0, 32'h00, 2'd2, 0, 0);  chk("sh_misalign_nowrite", read_data, 32'h0);
        access(1, 0, 32'h10, 2'd3, 0, 0);  chk("reserved_code", 32'(fault_code), 32'h3);

        access(0, 1, 32'h400, 2'd2, 0, 32'h0BADF00D);
        access(1, 0, 32'h400, 2'd2, 0, 0); chk("range_code", 32'(fault_code), 32'h2);
        access(1, 0, 32'h000, 2'd2, 0, 0); chk("range_nowrite", read_data, 32'h0);
        access(0, 1, 32'h3FC, 2'd2, 0, 32'h600DCAFE);
        access(1, 0, 32'h3FC, 2'd2, 0, 0); chk("lw_3fc", read_data, 32'h600DCAFE);

        access(0, 1, 32'h20, 2'd2, 0, 32'hAAAAAAAA);
        access(1, 1, 32'h20, 2'd2, 0, 32'h12345678);
`ifdef DATA_MEM_WRITE_FORWARD_EN
        chk("same_cycle_rw", read_data, 32'h12345678);
`else
        chk("same_cycle_rw", read_data, 32'hAAAAAAAA);
`endif
        access(1, 0, 32'h20, 2'd2, 0, 0); chk("rw_next_lw", read_data, 32'h12345678);

        // Asynchronous reset between edges, then a gated store while held.
        access(0, 1, 32'h30, 2'd2, 0, 32'hCAFEF00D);
        access(1, 0, 32'h30, 2'd2, 0, 0);
        #2 rst_n = 1'b0;
        sb.delete();
        model_rd = '0;
        #1;
        chk("async_rst_read_data", read_data, 32'h0);
        chk("async_rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("async_rst_fault", 32'(fault), 32'h0);
        @(negedge clk);
        access(1, 1, 32'h30, 2'd2, 0, 32'h0);
        chk("held_rd_valid", 32'(rd_valid), 32'h0);
        chk("held_read_data", read_data, 32'h0);
        rst_n = 1'b1;
        idle(1);
        access(1, 0, 32'h30, 2'd2, 0, 0); chk("after_reset_lw", read_data, 32'hCAFEF00D);

        for (int n = 0; n < 500; n++) begin
            case ($urandom_range(0, 19))
                0:       a = 32'h400 + $urandom_range(0, 4095);
                1:       a = $urandom;
                2, 3:    a = $urandom_range(0, BYTES - 1);
                default: a = $urandom_range(0, 127);
            endcase
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if (sz != 2'd3 && $urandom_range(0, 7) != 0) a = a & ~(32'(1 << sz) - 32'd1);
            rd = $urandom_range(0, 2) != 0;
            wr = $urandom_range(0, 2) == 0;
            access(rd, wr, a, sz, 1'($urandom_range(0, 1)), $urandom);
        end

        idle(3);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_bytelane.md
Name: data_mem_bytelane

Overview:
- Parametrised successor to the pipeline's word-only data memory, sitting in the MEM stage of the 32-bit MIPS core.
- Adds byte/halfword/word stores via byte-lane enables and sign/zero-extended sub-word loads (LB/LBU/LH/LHU/LW, SB/SH/SW).
- Adds alignment and range fault detection, and an asynchronous active-low reset on all output registers.
- Read data is registered, 1-cycle latency, so it lines up with the MEM/WB pipeline register.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, >= 4.
- ADDR_W, 32, byte-address width presented by the ALU.
- INIT_ZERO, 1, 1 = array zero-filled at simulation start (all DEPTH entries); 0 = left X.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- addr  input  ADDR_W  byte address
- write_data  input  32  store data, right-justified (SB uses [7:0], SH uses [15:0])
- MemRead  input  1  load request this cycle
- MemWrite  input  1  store request this cycle
- size  input  2  00 byte, 01 half, 10 word, 11 reserved
- ld_unsigned  input  1  1 = zero-extend sub-word load, 0 = sign-extend
- read_data  output  32  registered, extended load result
- rd_valid  output  1  pulses 1 the cycle after an accepted load
- fault  output  1  pulses 1 the cycle after any rejected access
- fault_code  output  2  01 misaligned, 10 out of range, 11 reserved size; 00 when fault=0

Behaviour:
- Reset (rst_n=0, asynchronous): read_data=0, rd_valid=0, fault=0, fault_code=00. Array contents are not cleared by reset. All outputs are held while rst_n=0.
- Word index = addr[log2(DEPTH)+1:2]; lane = addr[1:0]. Little-endian: lane 0 = bits [7:0].
- Access check (combinational, same cycle as request), evaluated in priority order:
  - size==11 -> reserved;
  - half with addr[0]=1, or word with addr[1:0]!=0 -> misaligned;
  - addr[ADDR_W-1:log2(DEPTH)+2] != 0 -> out of range.
- Rejected access:
  - No array write.
  - read_data holds its previous value; rd_valid=0.
  - Next cycle: fault=1 and fault_code set, for exactly one cycle.
- Store (accepted): at the rising edge, write only the enabled lanes.
  - SB: one lane, written with write_data[7:0].
  - SH: lanes {1,0} or {3,2}, written with write_data[15:0].
  - SW: all four lanes.
  - Other bytes of the word are untouched.
- Load (accepted): at the rising edge, capture the word, select the lane, extend per ld_unsigned (ignored for word loads) into read_data; rd_valid=1 for that one cycle.
- Cycles with no load: rd_valid=0 and read_data holds.
- Simultaneous MemRead and MemWrite, same word: the write is performed; load behaviour depends on WRITE_FORWARD_EN. Different words: both proceed independently.
- Both strobes 0: no state change except rd_valid and fault return to 0.
- Reset asserted mid-operation: output registers clear immediately. A store whose edge coincides with rst_n=0 is not performed (writes are gated by rst_n).
- Back-to-back accesses are allowed every cycle; no stalls, no busy state.

Optional Feature:
- Macro: DATA_MEM_WRITE_FORWARD_EN.
- Defined: a load to the same word as a simultaneous store returns the merged new word (stored lanes from write_data, remaining lanes from the array), then extends as normal. This is write-first behaviour.
- Undefined: that load returns the pre-write array contents (read-first), matching block-RAM inference.

Test Plan:
- Reset: drive rst_n=0 mid-cycle after a load -> read_data=0, rd_valid=0, fault=0 immediately. The word written before reset still reads back after release.
- SW 0xDEADBEEF at addr 0x10, then LB at 0x13 signed -> 0xFFFFFFDE. LBU at 0x10 -> 0x000000EF. LH at 0x12 -> 0xFFFFDEAD. LHU at 0x10 -> 0x0000BEEF. rd_valid asserted one cycle after each load.
- SB 0x55 at 0x11 over 0xDEADBEEF, then LW at 0x10 -> 0xDEAD55EF.
- LW at 0x02 -> fault=1, fault_code=01, read_data unchanged. SH at 0x01 -> fault_code=01, memory unchanged. size=11 -> fault_code=11.
- DEPTH=256: LW at 0x400 -> fault_code=10, no write. LW at 0x3FC -> valid.
- SW 0x12345678 and LW at the same address 0x20 in the same cycle, over old data 0xAAAAAAAA -> read_data=0x12345678 with DATA_MEM_WRITE_FORWARD_EN defined, 0xAAAAAAAA without. Next-cycle LW -> 0x12345678 in both cases.
